// File: rtl/instr_fetch.sv
// Instruction-fetch stage feeding the decode stage: fetches the word at the decode PC over a
// req/ack memory port and hands it to decode with a one-cycle enable, substituting NOOP on error.
module instr_fetch #(
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] NOOP    = 32'h00000013
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic [31:0] i_PC,
    input  logic        i_HOLD,
    output logic        o_IMEM_REQ,
    output logic [31:0] o_IMEM_ADDR,
    input  logic        i_IMEM_ACK,
    input  logic [31:0] i_IMEM_DATA,
    output logic [31:0] o_INSTRUCTION,
    output logic        o_EN,
    output logic        o_FETCH_ERR,
    output logic [31:0] o_ISSUE_CNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    // Last wait-counter value before a pending fetch is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [31:0] instr_reg, instr_next;
    logic        err_reg, err_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [31:0] issue_cnt_reg, issue_cnt_next;

    logic        pc_aligned;
    logic        fetch_req;
    logic        issue_en;

    assign pc_aligned = (i_PC[1:0] == 2'b00);

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state_reg     <= IDLE;
            instr_reg     <= NOOP;
            err_reg       <= 1'b0;
            wait_cnt_reg  <= 8'd0;
            issue_cnt_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            instr_reg     <= instr_next;
            err_reg       <= err_next;
            wait_cnt_reg  <= wait_cnt_next;
            issue_cnt_reg <= issue_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        instr_next     = instr_reg;
        err_next       = err_reg;
        wait_cnt_next  = wait_cnt_reg;
        issue_cnt_next = issue_cnt_reg;
        fetch_req      = 1'b0;
        issue_en       = 1'b0;

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                if (!pc_aligned) begin
                    // A misaligned PC is never put on the bus.
                    instr_next    = NOOP;
                    err_next      = 1'b1;
                    wait_cnt_next = 8'd0;
                    state_next    = ISSUE;
                end else begin
                    fetch_req = 1'b1;
                    if (i_IMEM_ACK) begin
                        // An ACK on the final allowed cycle still wins over the timeout.
                        instr_next    = i_IMEM_DATA;
                        err_next      = 1'b0;
                        wait_cnt_next = 8'd0;
                        state_next    = ISSUE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        instr_next    = NOOP;
                        err_next      = 1'b1;
                        wait_cnt_next = 8'd0;
                        state_next    = ISSUE;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end
            end

            ISSUE: begin
                issue_en = ~i_HOLD;
                if (!i_HOLD) begin
                    issue_cnt_next = issue_cnt_reg + 32'd1;
                    state_next     = FETCH;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs are forced quiet while reset is asserted, even mid-transaction.
    assign o_IMEM_REQ    = fetch_req & i_RSTn;
    assign o_IMEM_ADDR   = o_IMEM_REQ ? {i_PC[31:2], 2'b00} : 32'd0;
    assign o_EN          = issue_en & i_RSTn;
    assign o_FETCH_ERR   = issue_en & err_reg & i_RSTn;
    assign o_INSTRUCTION = instr_reg;
    assign o_ISSUE_CNT   = issue_cnt_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized fetches checked against
// a transaction-level model (latency, alignment and hold determine the delivered instruction).
module tb_instr_fetch;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] NOOP    = 32'h00000013;

    logic        i_CLK = 1'b0;
    logic        i_RSTn;
    logic [31:0] i_PC;
    logic        i_HOLD;
    logic        o_IMEM_REQ;
    logic [31:0] o_IMEM_ADDR;
    logic        i_IMEM_ACK;
    logic [31:0] i_IMEM_DATA;
    logic [31:0] o_INSTRUCTION;
    logic        o_EN;
    logic        o_FETCH_ERR;
    logic [31:0] o_ISSUE_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    int          obs_req_cycles;
    logic        obs_addr_bad, obs_en_early, obs_req_issue, obs_instr_moved;
    logic        obs_en, obs_err;
    logic [31:0] obs_instr, obs_cnt;
    logic [31:0] exp_cnt;

    instr_fetch #(.TIMEOUT(TIMEOUT), .NOOP(NOOP)) dut (
        .i_CLK        (i_CLK),
        .i_RSTn       (i_RSTn),
        .i_PC         (i_PC),
        .i_HOLD       (i_HOLD),
        .o_IMEM_REQ   (o_IMEM_REQ),
        .o_IMEM_ADDR  (o_IMEM_ADDR),
        .i_IMEM_ACK   (i_IMEM_ACK),
        .i_IMEM_DATA  (i_IMEM_DATA),
        .o_INSTRUCTION(o_INSTRUCTION),
        .o_EN         (o_EN),
        .o_FETCH_ERR  (o_FETCH_ERR),
        .o_ISSUE_CNT  (o_ISSUE_CNT)
    );

    always #5 i_CLK = ~i_CLK;

    // Transaction-level model: memory answers on request cycle 'lat' (0-based) or never.
    function automatic bit model_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

    function automatic int model_fetch_cycles(input logic [31:0] pc, input int lat);
        if (model_misaligned(pc)) return 1;
        if (lat < TIMEOUT) return lat + 1;
        return TIMEOUT;
    endfunction

    function automatic int model_req_cycles(input logic [31:0] pc, input int lat);
        if (model_misaligned(pc)) return 0;
        return model_fetch_cycles(pc, lat);
    endfunction

    function automatic logic model_err(input logic [31:0] pc, input int lat);
        return model_misaligned(pc) || (lat >= TIMEOUT);
    endfunction

    function automatic logic [31:0] model_instr(input logic [31:0] pc, input int lat, input logic [31:0] data);
        return model_err(pc, lat) ? NOOP : data;
    endfunction

    // Drives one fetch/issue transaction starting in the first FETCH cycle; records observations only.
    task automatic do_fetch(input logic [31:0] pc, input int lat, input int hold, input logic [31:0] data);
        int          n_fetch;
        logic [31:0] held_instr;
        n_fetch         = model_fetch_cycles(pc, lat);
        held_instr      = 32'd0;
        obs_req_cycles  = 0;
        obs_addr_bad    = 1'b0;
        obs_en_early    = 1'b0;
        obs_req_issue   = 1'b0;
        obs_instr_moved = 1'b0;
        for (int k = 0; k < n_fetch; k++) begin
            @(negedge i_CLK);
            i_PC = pc; i_HOLD = 1'b0; i_IMEM_ACK = 1'b0; i_IMEM_DATA = $urandom;
            #1;
            if (o_IMEM_REQ) begin
                obs_req_cycles++;
                if (o_IMEM_ADDR !== {pc[31:2], 2'b00}) obs_addr_bad = 1'b1;
                if (k == lat) begin i_IMEM_ACK = 1'b1; i_IMEM_DATA = data; end
            end
            if (o_EN || o_FETCH_ERR) obs_en_early = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge i_CLK);
            i_HOLD = 1'b1; i_IMEM_ACK = 1'($urandom_range(0, 1)); i_IMEM_DATA = $urandom;
            #1;
            if (o_EN || o_FETCH_ERR) obs_en_early = 1'b1;
            if (o_IMEM_REQ) obs_req_issue = 1'b1;
            if (h == 0) held_instr = o_INSTRUCTION;
            else if (o_INSTRUCTION !== held_instr) obs_instr_moved = 1'b1;
        end
        @(negedge i_CLK);
        i_HOLD = 1'b0; i_IMEM_ACK = 1'($urandom_range(0, 1)); i_IMEM_DATA = $urandom;
        #1;
        obs_en    = o_EN;
        obs_err   = o_FETCH_ERR;
        obs_instr = o_INSTRUCTION;
        if (o_IMEM_REQ) obs_req_issue = 1'b1;
        if (hold > 0 && obs_instr !== held_instr) obs_instr_moved = 1'b1;
        @(posedge i_CLK);
        #1;
        obs_cnt    = o_ISSUE_CNT;
        i_IMEM_ACK = 1'b0;
        $display("txn pc=%08h lat=%0d hold=%0d req_cycles=%0d instr=%08h en=%b err=%b cnt=%0d",
                 pc, lat, hold, obs_req_cycles, obs_instr, obs_en, obs_err, obs_cnt);
    endtask

    task automatic test_reset;
        i_RSTn = 1'b0; i_PC = 32'd0; i_HOLD = 1'b0; i_IMEM_ACK = 1'b0; i_IMEM_DATA = 32'd0;
        repeat (3) @(posedge i_CLK);
        @(negedge i_CLK);
        i_IMEM_ACK = 1'b1;
        #1;
        n_checks++; if (o_IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", o_IMEM_REQ); end
        n_checks++; if (o_EN !== 1'b0) begin n_fail++; $display("FAIL reset_en got=%b exp=0", o_EN); end
        n_checks++; if (o_INSTRUCTION !== NOOP) begin n_fail++; $display("FAIL reset_instr got=%08h exp=%08h", o_INSTRUCTION, NOOP); end
        n_checks++; if (o_ISSUE_CNT !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", o_ISSUE_CNT); end
        @(negedge i_CLK);
        i_RSTn = 1'b1; i_IMEM_ACK = 1'b0;
        #1;
        n_checks++; if (o_IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL idle_req got=%b exp=0", o_IMEM_REQ); end
        n_checks++; if (o_IMEM_ADDR !== 32'd0) begin n_fail++; $display("FAIL idle_addr got=%08h exp=0", o_IMEM_ADDR); end
        n_checks++; if (o_FETCH_ERR !== 1'b0) begin n_fail++; $display("FAIL idle_err got=%b exp=0", o_FETCH_ERR); end
        exp_cnt = 32'd0;
    endtask

    task automatic test_first_fetch;
        do_fetch(32'h0, 0, 0, 32'h00500093);
        exp_cnt++;
        n_checks++; if (obs_req_cycles !== 1) begin n_fail++; $display("FAIL first_req_cycles got=%0d exp=1", obs_req_cycles); end
        n_checks++; if (obs_instr !== 32'h00500093) begin n_fail++; $display("FAIL first_instr got=%08h exp=00500093", obs_instr); end
        n_checks++; if (obs_en !== 1'b1 || obs_err !== 1'b0) begin n_fail++; $display("FAIL first_en_err got=%b%b exp=10", obs_en, obs_err); end
        n_checks++; if (obs_cnt !== exp_cnt) begin n_fail++; $display("FAIL first_cnt got=%0d exp=%0d", obs_cnt, exp_cnt); end
        n_checks++; if (obs_addr_bad !== 1'b0) begin n_fail++; $display("FAIL first_addr got=bad exp=00000000"); end
    endtask

    task automatic test_delayed_ack;
        do_fetch(32'h10, 3, 0, 32'h00A00113);
        exp_cnt++;
        n_checks++; if (obs_req_cycles !== 4) begin n_fail++; $display("FAIL delay_req_cycles got=%0d exp=4", obs_req_cycles); end
        n_checks++; if (obs_addr_bad !== 1'b0) begin n_fail++; $display("FAIL delay_addr got=bad exp=00000010"); end
        n_checks++; if (obs_en_early !== 1'b0 || obs_en !== 1'b1) begin n_fail++; $display("FAIL delay_en_pulse got=early%b/en%b exp=early0/en1", obs_en_early, obs_en); end
        n_checks++; if (obs_instr !== 32'h00A00113) begin n_fail++; $display("FAIL delay_instr got=%08h exp=00a00113", obs_instr); end
        n_checks++; if (obs_cnt !== exp_cnt) begin n_fail++; $display("FAIL delay_cnt got=%0d exp=%0d", obs_cnt, exp_cnt); end
    endtask

    task automatic test_timeout;
        do_fetch(32'h20, TIMEOUT + 4, 0, 32'hDEADBEEF);
        exp_cnt++;
        n_checks++; if (obs_req_cycles !== 16) begin n_fail++; $display("FAIL timeout_req_cycles got=%0d exp=16", obs_req_cycles); end
        n_checks++; if (obs_instr !== 32'h00000013) begin n_fail++; $display("FAIL timeout_instr got=%08h exp=00000013", obs_instr); end
        n_checks++; if (obs_en !== 1'b1 || obs_err !== 1'b1) begin n_fail++; $display("FAIL timeout_en_err got=%b%b exp=11", obs_en, obs_err); end
        n_checks++; if (obs_cnt !== exp_cnt) begin n_fail++; $display("FAIL timeout_cnt got=%0d exp=%0d", obs_cnt, exp_cnt); end
        // ACK on the very last allowed cycle beats the timeout.
        do_fetch(32'h24, TIMEOUT - 1, 0, 32'h12345678);
        exp_cnt++;
        n_checks++; if (obs_req_cycles !== 16) begin n_fail++; $display("FAIL lastack_req_cycles got=%0d exp=16", obs_req_cycles); end
        n_checks++; if (obs_instr !== 32'h12345678 || obs_err !== 1'b0) begin n_fail++; $display("FAIL lastack_instr got=%08h err=%b exp=12345678 err=0", obs_instr, obs_err); end
    endtask

    task automatic test_misaligned;
        do_fetch(32'h6, 0, 0, 32'hCAFEF00D);
        exp_cnt++;
        n_checks++; if (obs_req_cycles !== 0) begin n_fail++; $display("FAIL misal_req_cycles got=%0d exp=0", obs_req_cycles); end
        n_checks++; if (obs_instr !== NOOP || obs_err !== 1'b1 || obs_en !== 1'b1) begin n_fail++; $display("FAIL misal_issue got=%08h en=%b err=%b exp=00000013 en=1 err=1", obs_instr, obs_en, obs_err); end
        n_checks++; if (obs_cnt !== exp_cnt) begin n_fail++; $display("FAIL misal_cnt got=%0d exp=%0d", obs_cnt, exp_cnt); end
    endtask

    task automatic test_hold;
        do_fetch(32'h30, 1, 4, 32'h00B00193);
        exp_cnt++;
        n_checks++; if (obs_en_early !== 1'b0) begin n_fail++; $display("FAIL hold_en got=1 exp=0 while held"); end
        n_checks++; if (obs_instr_moved !== 1'b0) begin n_fail++; $display("FAIL hold_instr_stable got=moved exp=stable"); end
        n_checks++; if (obs_req_issue !== 1'b0) begin n_fail++; $display("FAIL hold_req got=1 exp=0"); end
        n_checks++; if (obs_en !== 1'b1 || obs_instr !== 32'h00B00193) begin n_fail++; $display("FAIL hold_release got=en%b %08h exp=en1 00b00193", obs_en, obs_instr); end
        n_checks++; if (obs_cnt !== exp_cnt) begin n_fail++; $display("FAIL hold_cnt got=%0d exp=%0d", obs_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_fetch;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_CLK);
            i_PC = 32'h40; i_HOLD = 1'b0; i_IMEM_ACK = 1'b0;
            #1;
            n_checks++; if (o_IMEM_REQ !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_req got=%b exp=1", o_IMEM_REQ); end
        end
        @(negedge i_CLK);
        i_RSTn = 1'b0;
        #1;
        n_checks++; if (o_IMEM_REQ !== 1'b0 || o_EN !== 1'b0) begin n_fail++; $display("FAIL midrst_during got=req%b en%b exp=req0 en0", o_IMEM_REQ, o_EN); end
        @(negedge i_CLK);
        i_RSTn = 1'b1; i_IMEM_ACK = 1'b1; i_IMEM_DATA = 32'hBAADF00D;
        #1;
        exp_cnt = 32'd0;
        n_checks++; if (o_INSTRUCTION !== NOOP) begin n_fail++; $display("FAIL midrst_instr got=%08h exp=%08h", o_INSTRUCTION, NOOP); end
        n_checks++; if (o_ISSUE_CNT !== 32'd0) begin n_fail++; $display("FAIL midrst_cnt got=%0d exp=0", o_ISSUE_CNT); end
        n_checks++; if (o_IMEM_REQ !== 1'b0 || o_IMEM_ADDR !== 32'd0) begin n_fail++; $display("FAIL midrst_idle got=req%b addr=%08h exp=req0 addr=0", o_IMEM_REQ, o_IMEM_ADDR); end
        // The ACK seen in IDLE must not produce an issue; the next fetch starts fresh.
        do_fetch(32'h44, 2, 0, 32'h00C00213);
        exp_cnt++;
        n_checks++; if (obs_en_early !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_ack got=issue exp=none"); end
        n_checks++; if (obs_req_cycles !== 3 || obs_instr !== 32'h00C00213) begin n_fail++; $display("FAIL midrst_refetch got=%0d/%08h exp=3/00c00213", obs_req_cycles, obs_instr); end
        n_checks++; if (obs_cnt !== exp_cnt) begin n_fail++; $display("FAIL midrst_post_cnt got=%0d exp=%0d", obs_cnt, exp_cnt); end
    endtask

    task automatic test_random;
        logic [31:0] pc, data;
        int          lat, hold;
        for (int t = 0; t < 40; t++) begin
            pc = $urandom;
            if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
            lat  = int'($urandom_range(0, TIMEOUT + 2));
            hold = int'($urandom_range(0, 3));
            data = $urandom;
            do_fetch(pc, lat, hold, data);
            exp_cnt++;
            n_checks++; if (obs_req_cycles !== model_req_cycles(pc, lat)) begin n_fail++; $display("FAIL rnd%0d_req_cycles got=%0d exp=%0d", t, obs_req_cycles, model_req_cycles(pc, lat)); end
            n_checks++; if (obs_instr !== model_instr(pc, lat, data)) begin n_fail++; $display("FAIL rnd%0d_instr got=%08h exp=%08h", t, obs_instr, model_instr(pc, lat, data)); end
            n_checks++; if (obs_err !== model_err(pc, lat) || obs_en !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_en_err got=en%b err%b exp=en1 err%b", t, obs_en, obs_err, model_err(pc, lat)); end
            n_checks++; if (obs_en_early || obs_req_issue || obs_instr_moved || obs_addr_bad) begin n_fail++; $display("FAIL rnd%0d_protocol got=early%b req%b moved%b addr%b exp=0000", t, obs_en_early, obs_req_issue, obs_instr_moved, obs_addr_bad); end
            n_checks++; if (obs_cnt !== exp_cnt) begin n_fail++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", t, obs_cnt, exp_cnt); end
        end
    endtask

    initial begin
        test_reset;
        test_first_fetch;
        test_delayed_ack;
        test_timeout;
        test_misaligned;
        test_hold;
        test_reset_mid_fetch;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
